// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-ported synchronous RAM between two requesters using
//   round-robin arbitration. Each access walks IDLE -> ACCESS -> RESP, and
//   completion is reported to the owning requester as a one-cycle ack.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   a_req      port A (CPU data side) request, held until a_ack
//   a_we       port A write enable (1 = store), sampled at grant
//   a_addr     port A address, sampled at grant
//   a_wdata    port A store data, sampled at grant
//   a_ack      port A one-cycle completion pulse
//   a_rdata    port A load result, held until the next port A load completes
//   b_*        identical set for port B (program loader / DMA side)
//   mem_en     RAM access enable
//   mem_we     RAM write enable, only ever high together with mem_en
//   mem_addr   RAM address
//   mem_wdata  RAM write data
//   mem_rdata  RAM read data, valid the cycle after a read enable
//   busy       high whenever an access is in flight (state != IDLE)
module mem_arbiter #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned ADDR_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 a_req,
  input  logic                 a_we,
  input  logic [ADDR_SIZE-1:0] a_addr,
  input  logic [WORD_SIZE-1:0] a_wdata,
  output logic                 a_ack,
  output logic [WORD_SIZE-1:0] a_rdata,
  input  logic                 b_req,
  input  logic                 b_we,
  input  logic [ADDR_SIZE-1:0] b_addr,
  input  logic [WORD_SIZE-1:0] b_wdata,
  output logic                 b_ack,
  output logic [WORD_SIZE-1:0] b_rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  typedef enum logic {
    PORT_A,
    PORT_B
  } port_t;

  state_t               state_q;
  port_t                sel_q;
  port_t                last_grant_q;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [WORD_SIZE-1:0] wdata_q;
  logic                 we_q;
  logic                 a_ack_q;
  logic                 b_ack_q;
  logic [WORD_SIZE-1:0] a_rdata_q;
  logic [WORD_SIZE-1:0] b_rdata_q;

  logic                 elig_a;
  logic                 elig_b;
  logic                 grant_d;
  port_t                winner_d;

  // A port whose ack is high this cycle is still holding the req of the
  // access just completed, so it must not be granted again on that req.
  always_comb begin
    elig_a  = a_req & ~a_ack_q;
    elig_b  = b_req & ~b_ack_q;
    grant_d = elig_a | elig_b;
    if (elig_a && elig_b) begin
      winner_d = (last_grant_q == PORT_A) ? PORT_B : PORT_A;
    end else if (elig_b) begin
      winner_d = PORT_B;
    end else begin
      winner_d = PORT_A;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      sel_q        <= PORT_A;
      last_grant_q <= PORT_B;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      a_ack_q      <= 1'b0;
      b_ack_q      <= 1'b0;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
    end else begin
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_d) begin
            sel_q        <= winner_d;
            last_grant_q <= winner_d;
            if (winner_d == PORT_B) begin
              addr_q  <= b_addr;
              wdata_q <= b_wdata;
              we_q    <= b_we;
            end else begin
              addr_q  <= a_addr;
              wdata_q <= a_wdata;
              we_q    <= a_we;
            end
            state_q <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          state_q <= S_RESP;
        end
        S_RESP: begin
          if (sel_q == PORT_B) begin
            b_ack_q <= 1'b1;
            if (!we_q) begin
              b_rdata_q <= mem_rdata;
            end
          end else begin
            a_ack_q <= 1'b1;
            if (!we_q) begin
              a_rdata_q <= mem_rdata;
            end
          end
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // RAM strobes are decoded from the state so that an asynchronous reset
  // drops mem_en in the same instant, abandoning the access.
  assign mem_en    = (state_q == S_ACCESS);
  assign mem_we    = (state_q == S_ACCESS) & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != S_IDLE);

  assign a_ack   = a_ack_q;
  assign b_ack   = b_ack_q;
  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Drives mem_arbiter with directed sequences and randomized requests,
//   attaches a simple synchronous RAM, and compares every cycle against a
//   transaction-timeline reference model of the arbiter.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a_req = 1'b0, a_we = 1'b0;
  logic [15:0] a_addr = '0, a_wdata = '0;
  logic        b_req = 1'b0, b_we = 1'b0;
  logic [15:0] b_addr = '0, b_wdata = '0;
  logic        a_ack, b_ack, mem_en, mem_we, busy;
  logic [15:0] a_rdata, b_rdata, mem_addr, mem_wdata, mem_rdata;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.WORD_SIZE(16), .ADDR_SIZE(16)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  function automatic logic [15:0] init_word(input logic [15:0] a);
    return a ^ 16'hC3C3;
  endfunction

  // Synchronous RAM; unwritten words read as init_word(addr).
  bit [15:0]   ram [65536];
  bit          ram_wr [65536];
  logic [15:0] ram_q;
  assign mem_rdata = ram_q;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr]    <= mem_wdata;
        ram_wr[mem_addr] <= 1'b1;
      end else begin
        ram_q <= ram_wr[mem_addr] ? ram[mem_addr] : init_word(mem_addr);
      end
    end
  end

  // Reference model: a grant at edge g means the RAM is driven during cycle
  // g+1, the requester sees its ack during cycle g+3, and the arbiter can
  // grant again at edge g+3. Cycle c is the cycle that ends at edge c.
  int          cyc = 0;
  bit          m_valid = 1'b0;
  int          m_g = 0;
  bit          m_sel_b = 1'b0, m_we = 1'b0, m_last_b = 1'b1;
  logic [15:0] m_addr = '0, m_wd = '0, m_readval = '0;
  logic [15:0] m_rd_a = '0, m_rd_b = '0;
  bit [15:0]   sh [65536];
  bit          sh_wr [65536];
  bit          ea, eb;

  function automatic bit exp_ack(input bit port_b, input int c);
    return m_valid && (c == m_g + 3) && (m_sel_b == port_b);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_valid  = 1'b0;
      m_last_b = 1'b1;
      m_rd_a   = '0;
      m_rd_b   = '0;
    end else begin
      if (m_valid && cyc == m_g + 1) begin
        if (m_we) begin
          sh[m_addr]    = m_wd;
          sh_wr[m_addr] = 1'b1;
        end else begin
          m_readval = sh_wr[m_addr] ? sh[m_addr] : init_word(m_addr);
        end
      end
      if (m_valid && cyc == m_g + 2 && !m_we) begin
        if (m_sel_b) m_rd_b = m_readval;
        else         m_rd_a = m_readval;
      end
      if (!m_valid || cyc >= m_g + 3) begin
        ea = a_req && !exp_ack(1'b0, cyc);
        eb = b_req && !exp_ack(1'b1, cyc);
        if (ea || eb) begin
          m_sel_b  = eb && (!ea || !m_last_b);
          m_last_b = m_sel_b;
          m_valid  = 1'b1;
          m_g      = cyc;
          m_we     = m_sel_b ? b_we    : a_we;
          m_addr   = m_sel_b ? b_addr  : a_addr;
          m_wd     = m_sel_b ? b_wdata : a_wdata;
        end
      end
    end
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: actual %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Advance to the next falling edge and compare all outputs with the model.
  task automatic tick();
    bit en;
    @(negedge clk);
    if (!reset) begin
      en = m_valid && (cyc == m_g + 1);
      chk("mem_en", 32'(mem_en), 32'(en));
      chk("mem_we", 32'(mem_we), 32'(en && m_we));
      chk("busy", 32'(busy), 32'(m_valid && (cyc == m_g + 1 || cyc == m_g + 2)));
      chk("a_ack", 32'(a_ack), 32'(exp_ack(1'b0, cyc)));
      chk("b_ack", 32'(b_ack), 32'(exp_ack(1'b1, cyc)));
      chk("a_rdata", 32'(a_rdata), 32'(m_rd_a));
      chk("b_rdata", 32'(b_rdata), 32'(m_rd_b));
      if (en) begin
        chk("mem_addr", 32'(mem_addr), 32'(m_addr));
        if (m_we) chk("mem_wdata", 32'(mem_wdata), 32'(m_wd));
      end
    end
  endtask

  task automatic do_reset();
    #1 reset = 1'b1;
    a_req = 1'b0;
    b_req = 1'b0;
    #1 chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick();
    tick();
    #1 reset = 1'b0;
  endtask

  task automatic rnd_port(input logic ack_now, inout logic req, inout logic we,
                          inout logic [15:0] addr, inout logic [15:0] wd);
    we   = 1'($urandom_range(0, 1));
    addr = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 31));
    wd   = 16'($urandom);
    if (req && ack_now)  req = ($urandom_range(0, 3) == 0);
    else if (!req)       req = ($urandom_range(0, 2) == 0);
  endtask

  int na, nb, nseen, nen;
  bit prev_b;

  initial begin
    // Reset state
    tick();
    tick();
    chk("reset_a_ack", 32'(a_ack), 32'd0);
    chk("reset_b_ack", 32'(b_ack), 32'd0);
    chk("reset_a_rdata", 32'(a_rdata), 32'd0);
    chk("reset_b_rdata", 32'(b_rdata), 32'd0);
    chk("reset_mem_en", 32'(mem_en), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    #1 reset = 1'b0;

    // A store to 0x0010
    a_req = 1'b1; a_we = 1'b1; a_addr = 16'h0010; a_wdata = 16'hBEEF;
    tick();
    chk("t1_mem_en", 32'(mem_en), 32'd1);
    chk("t1_mem_we", 32'(mem_we), 32'd1);
    chk("t1_mem_addr", 32'(mem_addr), 32'h0010);
    chk("t1_mem_wdata", 32'(mem_wdata), 32'hBEEF);
    tick();
    chk("t1_ack_c2", 32'(a_ack), 32'd0);
    tick();
    chk("t1_ack_c3", 32'(a_ack), 32'd1);
    chk("t1_rdata", 32'(a_rdata), 32'h0000);
    a_req = 1'b0;
    tick();
    chk("t1_ack_c4", 32'(a_ack), 32'd0);

    // A load from 0x0010, result held
    a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0010;
    tick();
    tick();
    tick();
    chk("t2_ack", 32'(a_ack), 32'd1);
    chk("t2_rdata", 32'(a_rdata), 32'hBEEF);
    a_req = 1'b0;
    repeat (10) tick();
    chk("t2_rdata_held", 32'(a_rdata), 32'hBEEF);

    // Simultaneous reads after reset: A first, then B
    do_reset();
    a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0001;
    b_req = 1'b1; b_we = 1'b0; b_addr = 16'h0002;
    tick();
    chk("t3_addr_a", 32'(mem_addr), 32'h0001);
    tick();
    tick();
    chk("t3_a_ack", 32'(a_ack), 32'd1);
    chk("t3_a_rdata", 32'(a_rdata), 32'hC3C2);
    chk("t3_b_ack_c3", 32'(b_ack), 32'd0);
    a_req = 1'b0;
    tick();
    chk("t3_addr_b", 32'(mem_addr), 32'h0002);
    tick();
    tick();
    chk("t3_b_ack", 32'(b_ack), 32'd1);
    chk("t3_b_rdata", 32'(b_rdata), 32'hC3C1);
    b_req = 1'b0;

    // Continuous contention for 12 accesses
    a_req = 1'b1; b_req = 1'b1;
    na = 0; nb = 0; nseen = 0; prev_b = 1'b1;
    for (int i = 0; i < 36; i++) begin
      a_we = 1'($urandom_range(0, 1)); a_addr = 16'($urandom_range(64, 95)); a_wdata = 16'($urandom);
      b_we = 1'($urandom_range(0, 1)); b_addr = 16'($urandom_range(64, 95)); b_wdata = 16'($urandom);
      tick();
      if (a_ack || b_ack) begin
        chk("t4_single_ack", 32'(a_ack && b_ack), 32'd0);
        chk("t4_alternate", 32'(b_ack), 32'(!prev_b));
        prev_b = b_ack;
        nseen++;
        if (a_ack) na++;
        if (b_ack) nb++;
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    chk("t4_a_acks", 32'(na), 32'd6);
    chk("t4_b_acks", 32'(nb), 32'd6);

    // B holds req one cycle past its ack: still exactly one access
    tick();
    b_req = 1'b1; b_we = 1'b0; b_addr = 16'h0003;
    nen = 0; nb = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (mem_en) nen++;
      if (b_ack) nb++;
      if (i == 4) b_req = 1'b0;
    end
    chk("t5_accesses", 32'(nen), 32'd1);
    chk("t5_b_acks", 32'(nb), 32'd1);
    chk("t5_b_rdata", 32'(b_rdata), 32'hC3C0);

    // Reset during ACCESS of an A write
    a_req = 1'b1; a_we = 1'b1; a_addr = 16'h0020; a_wdata = 16'h1234;
    tick();
    chk("t6_in_access", 32'(mem_en), 32'd1);
    #1 reset = 1'b1;
    a_req = 1'b0;
    #1 chk("t6_mem_en", 32'(mem_en), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    tick();
    chk("t6_no_ack_r", 32'(a_ack), 32'd0);
    tick();
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_no_ack", 32'(a_ack), 32'd0);
    end
    a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0020;
    tick();
    chk("t6_mem_addr", 32'(mem_addr), 32'h0020);
    tick();
    tick();
    chk("t6_ack", 32'(a_ack), 32'd1);
    chk("t6_rdata", 32'(a_rdata), 32'hC3E3);
    a_req = 1'b0;

    // Randomized traffic with occasional resets
    for (int i = 0; i < 2500; i++) begin
      tick();
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        rnd_port(a_ack, a_req, a_we, a_addr, a_wdata);
        rnd_port(b_ack, b_req, b_we, b_addr, b_wdata);
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    repeat (8) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
